// File: rtl/shift_reg_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shift_reg_multi : universal shift/LFSR register run by a command handshake |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module shift_reg_multi #(
  parameter int              WIDTH     = 8,
  parameter int              CNT_W     = 4,
  parameter logic [WIDTH-1:0] LFSR_MASK = 8'hB8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   q_q;
  logic               sout_q;
  logic [CNT_W-1:0]   rem_q;
  logic [3:0]         op_q;
  logic               armed_q;

  logic [3:0]         op_sel;
  logic [WIDTH-1:0]   step_q_d;
  logic               step_sout_d;
  logic               cmd_is_shift;
  logic               accept;

  assign cmd_is_shift = (cmd_op >= 4'd2) && (cmd_op <= 4'd9);
  assign accept       = cmd_valid && cmd_ready;

  // The step on the accept edge uses the live opcode; later steps use the latched one.
  always_comb begin
    op_sel      = (state_q == S_IDLE) ? cmd_op : op_q;
    step_q_d    = q_q;
    step_sout_d = sout_q;
    case (op_sel)
      4'd2: begin step_q_d = {1'b0, q_q[WIDTH-1:1]};         step_sout_d = q_q[0];       end
      4'd3: begin step_q_d = {q_q[WIDTH-2:0], 1'b0};         step_sout_d = q_q[WIDTH-1]; end
      4'd4: begin step_q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]}; step_sout_d = q_q[0];       end
      4'd5: begin step_q_d = {sin, q_q[WIDTH-1:1]};          step_sout_d = q_q[0];       end
      4'd6: begin step_q_d = {q_q[0], q_q[WIDTH-1:1]};       step_sout_d = q_q[0];       end
      4'd7: begin step_q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; step_sout_d = q_q[WIDTH-1]; end
      4'd8: begin
        step_sout_d = q_q[0];
        if (q_q == '0) begin
          step_q_d = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          step_q_d = {1'b0, q_q[WIDTH-1:1]} ^ (q_q[0] ? LFSR_MASK : '0);
        end
      end
      4'd9: begin step_q_d = {q_q[WIDTH-2:0], sin};          step_sout_d = q_q[WIDTH-1]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      sout_q  <= 1'b0;
      rem_q   <= '0;
      op_q    <= 4'd0;
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q <= cmd_op;
            if (cmd_is_shift && (cmd_cnt != '0)) begin
              q_q     <= step_q_d;
              sout_q  <= step_sout_d;
              rem_q   <= cmd_cnt - 1'b1;
              state_q <= (cmd_cnt == CNT_W'(1)) ? S_DONE : S_RUN;
            end else begin
              if (cmd_op == 4'd0) begin
                q_q <= '0;
              end else if (cmd_op == 4'd1) begin
                q_q <= d;
              end
              state_q <= S_DONE;
            end
          end
        end
        S_RUN: begin
          q_q    <= step_q_d;
          sout_q <= step_sout_d;
          rem_q  <= rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Ready is held off until the first edge after reset release.
  assign cmd_ready = armed_q && (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign q         = q_q;
  assign sout      = sout_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_shift_reg_multi : directed + random command bench with arithmetic model |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_shift_reg_multi;

  logic       clk;
  logic       clr_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [3:0] cmd_cnt;
  logic [7:0] d;
  logic       sin;
  logic [7:0] q;
  logic       sout;
  logic       busy;
  logic       done;

  int         total;
  int         bad;
  logic [7:0] exp_q;
  logic       exp_sout;

  shift_reg_multi #(
    .WIDTH     (8),
    .CNT_W     (4),
    .LFSR_MASK (8'hB8)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .d         (d),
    .sin       (sin),
    .q         (q),
    .sout      (sout),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One step of each operation as plain integer arithmetic on an 8-bit value.
  function automatic logic [8:0] mstep(input int op, input logic [7:0] qv,
                                       input logic s, input logic so);
    int   x;
    int   r;
    int   si;
    logic o;
    x  = int'(qv);
    si = s ? 1 : 0;
    r  = x;
    o  = so;
    case (op)
      2: begin o = (x % 2) != 0;  r = x / 2;                         end
      3: begin o = x >= 128;      r = (x * 2) % 256;                 end
      4: begin o = (x % 2) != 0;  r = x / 2 + ((x >= 128) ? 128 : 0); end
      5: begin o = (x % 2) != 0;  r = x / 2 + si * 128;              end
      6: begin o = (x % 2) != 0;  r = x / 2 + (x % 2) * 128;         end
      7: begin o = x >= 128;      r = (x * 2) % 256 + x / 128;       end
      8: begin
        o = (x % 2) != 0;
        r = (x == 0) ? 1 : ((x / 2) ^ (((x % 2) != 0) ? 'hB8 : 0));
      end
      9: begin o = x >= 128;      r = (x * 2) % 256 + si;            end
      default: ;
    endcase
    return {o, r[7:0]};
  endfunction

  // Issues one command and follows it through to IDLE, checking every cycle.
  task automatic run_cmd(input int op, input int cnt, input logic [7:0] dd,
                         input logic [15:0] sinv, input bit hold);
    int         n;
    int         iters;
    logic [8:0] r;
    n     = (op >= 2 && op <= 9) ? cnt : 0;
    iters = (n == 0) ? 1 : n;
    @(negedge clk);
    check("ready_before", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = 4'(op);
    cmd_cnt   = 4'(cnt);
    d         = dd;
    sin       = sinv[0];
    for (int i = 0; i < iters; i++) begin
      if (n == 0) begin
        if (op == 0) exp_q = 8'h00;
        else if (op == 1) exp_q = dd;
      end else begin
        r        = mstep(op, exp_q, sinv[i], exp_sout);
        exp_sout = r[8];
        exp_q    = r[7:0];
      end
      @(negedge clk);
      check("q", 32'(q), 32'(exp_q));
      check("sout", 32'(sout), 32'(exp_sout));
      check("busy", 32'(busy), 32'd1);
      check("done", 32'(done), (i == iters - 1) ? 32'd1 : 32'd0);
      check("ready_busy", 32'(cmd_ready), 32'd0);
      if (!hold) begin
        cmd_valid = 1'($urandom);
        cmd_op    = 4'($urandom);
        cmd_cnt   = 4'($urandom);
        d         = 8'($urandom);
      end
      if (i + 1 < 16) sin = sinv[i+1];
    end
    @(negedge clk);
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ready", 32'(cmd_ready), 32'd1);
    check("idle_q", 32'(q), 32'(exp_q));
    cmd_valid = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    exp_q     = 8'h00;
    exp_sout  = 1'b0;
    clr_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 4'd0;
    cmd_cnt   = 4'd0;
    d         = 8'h00;
    sin       = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_q", 32'(q), 32'd0);
    check("rst_sout", 32'(sout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    clr_n = 1'b1;
    #1 check("ready_at_release", 32'(cmd_ready), 32'd0);

    // Rotate right from A5
    run_cmd(1, 0, 8'hA5, 16'h0, 1'b0);
    run_cmd(6, 3, 8'h00, 16'h0, 1'b0);
    check("t1_q", 32'(q), 32'hB4);

    // Arithmetic vs logical right shift of 80
    run_cmd(1, 0, 8'h80, 16'h0, 1'b0);
    run_cmd(4, 2, 8'h00, 16'h0, 1'b0);
    check("t2_asr", 32'(q), 32'hE0);
    run_cmd(1, 0, 8'h80, 16'h0, 1'b0);
    run_cmd(2, 2, 8'h00, 16'h0, 1'b0);
    check("t2_lsr", 32'(q), 32'h20);

    // LFSR steps and zero seed
    run_cmd(1, 0, 8'h01, 16'h0, 1'b0);
    run_cmd(8, 2, 8'h00, 16'h0, 1'b0);
    check("t3_lfsr", 32'(q), 32'h5C);
    run_cmd(1, 0, 8'h00, 16'h0, 1'b0);
    run_cmd(8, 1, 8'h00, 16'h0, 1'b0);
    check("t3_seed", 32'(q), 32'h01);

    // Serial inputs
    run_cmd(1, 0, 8'h00, 16'h0, 1'b0);
    run_cmd(5, 3, 8'h00, 16'h0005, 1'b0);
    check("t4_sri", 32'(q), 32'hA0);
    run_cmd(9, 2, 8'h00, 16'h0003, 1'b0);
    check("t4_sli", 32'(q), 32'h83);

    // Zero count and cmd_valid held through a long command
    run_cmd(1, 0, 8'h3C, 16'h0, 1'b0);
    run_cmd(7, 0, 8'h00, 16'h0, 1'b0);
    check("t5_cnt0", 32'(q), 32'h3C);
    run_cmd(7, 15, 8'h00, 16'h0, 1'b1);
    check("t5_hold", 32'(q), 32'h1E);

    // Reset during the second step of LSL cnt=8
    run_cmd(1, 0, 8'hFF, 16'h0, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 4'd3;
    cmd_cnt   = 4'd8;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("t6_step1", 32'(q), 32'hFE);
    #2 clr_n = 1'b0;
    #1;
    check("t6_rst_q", 32'(q), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_sout", 32'(sout), 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    #1 check("t6_ready_release", 32'(cmd_ready), 32'd0);
    exp_q    = 8'h00;
    exp_sout = 1'b0;
    run_cmd(1, 0, 8'h5A, 16'h0, 1'b0);
    check("t6_load", 32'(q), 32'h5A);

    // Random commands against the model
    for (int k = 0; k < 40; k++) begin
      run_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 6)),
              8'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
